// File: rtl/cgra_im_loader_pkg.sv
// Shared definitions for the CGRA instruction-memory loader: FSM encoding,
// address-field geometry, control-register select and status/control bit positions.
package cgra_im_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } loaderState_t;

  localparam int SEL_W = 8;
  localparam logic [SEL_W-1:0] CTRL_SEL = 8'hFF;

  // SEL sits just above the word field, which is IM address width plus one bit.
  function automatic int selLsb(input int imAddrW);
    return imAddrW + 3;
  endfunction

  localparam int SEL_LSB = selLsb(8);

  localparam int STAT_DONE   = 0;
  localparam int STAT_HALTED = 1;
  localparam int STAT_ERR    = 2;

  localparam int CTRL_DONE   = 0;
  localparam int CTRL_RESET  = 1;
  localparam int CTRL_CLRERR = 2;

endpackage

// File: rtl/cgra_loader_decode.sv
// Combinational decode of the latched memory select and word address into a
// one-hot IM strobe plus target-class and validity flags.
module cgra_loader_decode
  import cgra_im_loader_pkg::*;
#(
  parameter int IM_MEM_ADDR_WIDTH = 8,
  parameter int NUM_ID            = 10,
  parameter int NUM_IMM           = 4
) (
  input  logic [SEL_W-1:0]             sel,
  input  logic [IM_MEM_ADDR_WIDTH:0]   word,
  output logic [NUM_ID+NUM_IMM-1:0]    strobe,
  output logic                         isId,
  output logic                         isImm,
  output logic                         isCtrl,
  output logic                         wordOk,
  output logic                         immHigh
);

  always_comb begin
    isId    = int'(sel) < NUM_ID;
    isImm   = (int'(sel) >= NUM_ID) && (int'(sel) < NUM_ID + NUM_IMM);
    isCtrl  = (sel == CTRL_SEL);
    // ID memories only span half the word field; the top half is out of range.
    wordOk  = isCtrl || isImm || (isId && !word[IM_MEM_ADDR_WIDTH]);
    immHigh = word[0];
    strobe  = '0;
    for (int i = 0; i < NUM_ID + NUM_IMM; i++) begin
      strobe[i] = (int'(sel) == i) && (isImm || (isId && !word[IM_MEM_ADDR_WIDTH]));
    end
  end

endmodule

// File: rtl/cgra_im_loader.sv
// DTL slave that loads CGRA ID/IMM instruction memories, sequences core reset and
// config-done, and returns a status word on reads. Optional sticky error flag
// enabled by defining CGRA_LOADER_ERR_STATUS_EN.
module cgra_im_loader
  import cgra_im_loader_pkg::*;
#(
  parameter int INTERFACE_WIDTH       = 32,
  parameter int INTERFACE_ADDR_WIDTH  = 32,
  parameter int INTERFACE_BLOCK_WIDTH = 5,
  parameter int I_WIDTH               = 12,
  parameter int I_IMM_WIDTH           = 33,
  parameter int IM_MEM_ADDR_WIDTH     = 8,
  parameter int NUM_ID                = 10,
  parameter int NUM_IMM               = 4
) (
  input  logic                               iClk,
  input  logic                               iReset,
  input  logic                               iDTL_Loader_CommandValid,
  input  logic                               iDTL_Loader_CommandReadWrite,
  input  logic [INTERFACE_ADDR_WIDTH-1:0]    iDTL_Loader_Address,
  input  logic [INTERFACE_BLOCK_WIDTH-1:0]   iDTL_Loader_BlockSize,
  input  logic                               iDTL_Loader_WriteValid,
  input  logic                               iDTL_Loader_WriteLast,
  input  logic [INTERFACE_WIDTH/8-1:0]       iDTL_Loader_WriteEnable,
  input  logic [INTERFACE_WIDTH-1:0]         iDTL_Loader_WriteData,
  input  logic                               iDTL_Loader_ReadAccept,
  output logic                               oDTL_Loader_CommandAccept,
  output logic                               oDTL_Loader_WriteAccept,
  output logic                               oDTL_Loader_ReadValid,
  output logic                               oDTL_Loader_ReadLast,
  output logic [INTERFACE_WIDTH-1:0]         oDTL_Loader_ReadData,
  input  logic                               iHalted,
  output logic [NUM_ID+NUM_IMM-1:0]          oIM_WriteEnable,
  output logic [IM_MEM_ADDR_WIDTH-1:0]       oIM_WriteAddress,
  output logic [I_WIDTH-1:0]                 oIM_WriteData,
  output logic [I_IMM_WIDTH-1:0]             oIM_WriteData_IMM,
  output logic                               oCoreReset,
  output logic                               oConfigDone
);

  localparam int NUM_MEM = NUM_ID + NUM_IMM;
  localparam int SEL_LO  = selLsb(IM_MEM_ADDR_WIDTH);

  loaderState_t                       state;
  logic                               cmdAccept, wrAccept;
  logic                               readValid, readLast;
  logic [INTERFACE_WIDTH-1:0]         readData;
  logic [SEL_W-1:0]                   selQ;
  logic [IM_MEM_ADDR_WIDTH:0]         wordQ;
  logic [INTERFACE_BLOCK_WIDTH-1:0]   beatCnt, blockSizeQ;
  logic [INTERFACE_WIDTH-1:0]         immLowQ;
  logic                               immLowValid;
  logic [NUM_MEM-1:0]                 imWe;
  logic [IM_MEM_ADDR_WIDTH-1:0]       imAddr;
  logic [I_WIDTH-1:0]                 imData;
  logic [I_IMM_WIDTH-1:0]             imDataImm;
  logic                               configDone, coreReset;
  logic                               errBit;

  logic [NUM_MEM-1:0]                 decStrobe;
  logic                               isId, isImm, isCtrl, wordOk, immHigh;
  logic                               beatVld_p0, dataBeat_p0;
  logic                               unusedAddrBits;

  assign unusedAddrBits = ^{iDTL_Loader_Address[1:0],
                            iDTL_Loader_Address[INTERFACE_ADDR_WIDTH-1:SEL_LO+SEL_W]};

  function automatic logic [INTERFACE_WIDTH-1:0] statusWord(input logic done,
                                                            input logic halted,
                                                            input logic err);
    logic [INTERFACE_WIDTH-1:0] s;
    s = '0;
    s[STAT_DONE]   = done;
    s[STAT_HALTED] = halted;
    s[STAT_ERR]    = err;
    return s;
  endfunction

  cgra_loader_decode #(
    .IM_MEM_ADDR_WIDTH(IM_MEM_ADDR_WIDTH),
    .NUM_ID           (NUM_ID),
    .NUM_IMM          (NUM_IMM)
  ) uDecode (
    .sel    (selQ),
    .word   (wordQ),
    .strobe (decStrobe),
    .isId   (isId),
    .isImm  (isImm),
    .isCtrl (isCtrl),
    .wordOk (wordOk),
    .immHigh(immHigh)
  );

  // ---- p0: beat acceptance at the DTL boundary ----
  assign beatVld_p0  = iDTL_Loader_WriteValid && wrAccept;
  assign dataBeat_p0 = beatVld_p0 && (|iDTL_Loader_WriteEnable);

  // ---- p1: registered FSM, IM strobes and read channel ----
  always_ff @(posedge iClk) begin
    if (iReset) begin
      state       <= ST_IDLE;
      cmdAccept   <= 1'b0;
      wrAccept    <= 1'b0;
      readValid   <= 1'b0;
      readLast    <= 1'b0;
      readData    <= '0;
      selQ        <= '0;
      wordQ       <= '0;
      beatCnt     <= '0;
      blockSizeQ  <= '0;
      immLowValid <= 1'b0;
      imWe        <= '0;
      imAddr      <= '0;
      imData      <= '0;
      imDataImm   <= '0;
      configDone  <= 1'b0;
      coreReset   <= 1'b1;
    end else begin
      imWe <= '0;
      case (state)
        ST_IDLE: begin
          if (cmdAccept && iDTL_Loader_CommandValid) begin
            cmdAccept   <= 1'b0;
            selQ        <= iDTL_Loader_Address[SEL_LO +: SEL_W];
            wordQ       <= iDTL_Loader_Address[2 +: IM_MEM_ADDR_WIDTH+1];
            blockSizeQ  <= iDTL_Loader_BlockSize;
            beatCnt     <= '0;
            immLowValid <= 1'b0;
            if (iDTL_Loader_CommandReadWrite) begin
              state    <= ST_WRITE;
              wrAccept <= 1'b1;
            end else begin
              state     <= ST_READ;
              readValid <= 1'b1;
              readLast  <= (iDTL_Loader_BlockSize == '0);
              readData  <= statusWord(configDone, iHalted, errBit);
            end
          end else begin
            cmdAccept <= 1'b1;
          end
        end
        ST_WRITE: begin
          if (beatVld_p0) begin
            if (dataBeat_p0) begin
              if (isCtrl) begin
                if (iDTL_Loader_WriteData[CTRL_RESET]) begin
                  coreReset  <= 1'b1;
                  configDone <= 1'b0;
                end else if (iDTL_Loader_WriteData[CTRL_DONE]) begin
                  coreReset  <= 1'b0;
                  configDone <= 1'b1;
                end
              end else if (isId && wordOk) begin
                imWe   <= decStrobe;
                imAddr <= wordQ[IM_MEM_ADDR_WIDTH-1:0];
                imData <= iDTL_Loader_WriteData[I_WIDTH-1:0];
              end else if (isImm) begin
                // IMM words arrive as low half on the even beat, top bit on the odd beat.
                if (!immHigh) begin
                  immLowQ     <= iDTL_Loader_WriteData;
                  immLowValid <= 1'b1;
                end else if (immLowValid) begin
                  imWe        <= decStrobe;
                  imAddr      <= wordQ[IM_MEM_ADDR_WIDTH:1];
                  imDataImm   <= {iDTL_Loader_WriteData[0], immLowQ};
                  immLowValid <= 1'b0;
                end
              end
            end
            wordQ   <= wordQ + 1'b1;
            beatCnt <= beatCnt + 1'b1;
            if ((beatCnt == blockSizeQ) || iDTL_Loader_WriteLast) begin
              state     <= ST_IDLE;
              wrAccept  <= 1'b0;
              cmdAccept <= 1'b1;
            end
          end
        end
        ST_READ: begin
          if (readValid && iDTL_Loader_ReadAccept) begin
            if (beatCnt == blockSizeQ) begin
              state     <= ST_IDLE;
              readValid <= 1'b0;
              readLast  <= 1'b0;
              cmdAccept <= 1'b1;
            end else begin
              beatCnt  <= beatCnt + 1'b1;
              readLast <= ((beatCnt + 1'b1) == blockSizeQ);
              readData <= statusWord(configDone, iHalted, errBit);
            end
          end
        end
        default: begin
          state     <= ST_IDLE;
          cmdAccept <= 1'b0;
          wrAccept  <= 1'b0;
          readValid <= 1'b0;
          readLast  <= 1'b0;
        end
      endcase
    end
  end

`ifdef CGRA_LOADER_ERR_STATUS_EN
  logic errQ;
  logic beatErr;

  assign beatErr = (!isCtrl && !isImm && !isId) ||
                   (isId && !wordOk) ||
                   (isImm && immHigh && !immLowValid);

  always_ff @(posedge iClk) begin
    if (iReset) begin
      errQ <= 1'b0;
    end else if (dataBeat_p0) begin
      if (isCtrl && iDTL_Loader_WriteData[CTRL_CLRERR]) begin
        errQ <= 1'b0;
      end else if (beatErr) begin
        errQ <= 1'b1;
      end
    end
  end

  assign errBit = errQ;
`else
  assign errBit = 1'b0;
`endif

  assign oDTL_Loader_CommandAccept = cmdAccept;
  assign oDTL_Loader_WriteAccept   = wrAccept;
  assign oDTL_Loader_ReadValid     = readValid;
  assign oDTL_Loader_ReadLast      = readLast;
  assign oDTL_Loader_ReadData      = readData;
  assign oIM_WriteEnable           = imWe;
  assign oIM_WriteAddress          = imAddr;
  assign oIM_WriteData             = imData;
  assign oIM_WriteData_IMM         = imDataImm;
  assign oCoreReset                = coreReset;
  assign oConfigDone               = configDone;

endmodule
